// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : picorv32_mem_arbiter                                            |
// | Purpose  : Round-robin N:1 arbiter for the picorv32 native memory bus with |
// |            registered request/response stages. Optional bus-timeout       |
// |            watchdog enabled by defining PICORV32_ARB_TIMEOUT_EN.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module picorv32_mem_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            up_valid,
    input  logic [NUM_PORTS-1:0]            up_instr,
    input  logic [NUM_PORTS*ADDR_W-1:0]     up_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     up_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   up_wstrb,
    output logic [NUM_PORTS-1:0]            up_ready,
    output logic [DATA_W-1:0]               up_rdata,
    output logic                            mem_valid,
    output logic                            mem_instr,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W/8-1:0]             mem_wstrb,
    input  logic                            mem_ready,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic                            err_timeout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_instr_q, mem_instr_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]      mem_wstrb_q, mem_wstrb_d;
    logic [NUM_PORTS-1:0]   up_ready_q, up_ready_d;
    logic [DATA_W-1:0]      up_rdata_q, up_rdata_d;

`ifdef PICORV32_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_timeout_q, err_timeout_d;
`else
    logic                   w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

    logic                   w_pick_found;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [IDX_W-1:0]       w_cand;

    // Walk from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_cand = IDX_W'((int'(last_grant_q) + i) % NUM_PORTS);
            if (up_valid[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_valid_d  = mem_valid_q;
        mem_instr_d  = mem_instr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        up_ready_d   = up_ready_q;
        up_rdata_d   = up_rdata_q;
`ifdef PICORV32_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_timeout_d = err_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_pick_found) begin
                    grant_d     = w_pick_idx;
                    mem_valid_d = 1'b1;
                    mem_instr_d = up_instr[w_pick_idx];
                    mem_addr_d  = up_addr[w_pick_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = up_wdata[w_pick_idx*DATA_W +: DATA_W];
                    mem_wstrb_d = up_wstrb[w_pick_idx*STRB_W +: STRB_W];
`ifdef PICORV32_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d         = 1'b0;
                    up_rdata_d          = mem_rdata;
                    up_ready_d          = '0;
                    up_ready_d[grant_q] = 1'b1;
                    state_d             = S_RESP;
                end
`ifdef PICORV32_ARB_TIMEOUT_EN
                // Abort looks like a normal completion to the master, flagged by err_timeout.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_valid_d         = 1'b0;
                    up_rdata_d          = '1;
                    up_ready_d          = '0;
                    up_ready_d[grant_q] = 1'b1;
                    err_timeout_d       = 1'b1;
                    state_d             = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                up_ready_d   = '0;
                last_grant_d = grant_q;
`ifdef PICORV32_ARB_TIMEOUT_EN
                err_timeout_d = 1'b0;
`endif
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            mem_valid_q  <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            up_ready_q   <= '0;
            up_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_valid_q  <= mem_valid_d;
            mem_instr_q  <= mem_instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            up_ready_q   <= up_ready_d;
            up_rdata_q   <= up_rdata_d;
        end
    end

`ifdef PICORV32_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign up_ready  = up_ready_q;
    assign up_rdata  = up_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_picorv32_mem_arbiter                                         |
// | Purpose  : Directed self-checking bench for picorv32_mem_arbiter (2 ports);|
// |            timeout scenarios run when PICORV32_ARB_TIMEOUT_EN is defined.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_picorv32_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk;
    logic               reset;
    logic [NP-1:0]      up_valid;
    logic [NP-1:0]      up_instr;
    logic [NP*AW-1:0]   up_addr;
    logic [NP*DW-1:0]   up_wdata;
    logic [NP*DW/8-1:0] up_wstrb;
    logic [NP-1:0]      up_ready;
    logic [DW-1:0]      up_rdata;
    logic               mem_valid;
    logic               mem_instr;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW/8-1:0]    mem_wstrb;
    logic               mem_ready;
    logic [DW-1:0]      mem_rdata;
    logic               err_timeout;

    int n_vec;
    int n_err;

    picorv32_mem_arbiter #(
        .NUM_PORTS      (NP),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .up_valid    (up_valid),
        .up_instr    (up_instr),
        .up_addr     (up_addr),
        .up_wdata    (up_wdata),
        .up_wstrb    (up_wstrb),
        .up_ready    (up_ready),
        .up_rdata    (up_rdata),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_valid();
        for (int i = 0; i < 20 && mem_valid !== 1'b1; i++) step();
        check("grant_wait", 64'(mem_valid), 64'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        up_valid  = '0;
        up_instr  = '0;
        up_addr   = '0;
        up_wdata  = '0;
        up_wstrb  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        step();
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_up_ready",  64'(up_ready), 64'd0);
        check("rst_up_rdata",  64'(up_rdata), 64'd0);
        check("rst_mem_addr",  64'(mem_addr), 64'd0);
        check("rst_err",       64'(err_timeout), 64'd0);
        reset = 1'b0;

        // Single zero-wait read from port 0
        up_valid       = 2'b01;
        up_instr       = 2'b01;
        up_addr[31:0]  = 32'h0000_0100;
        step();
        check("t1_mem_valid", 64'(mem_valid), 64'd1);
        check("t1_mem_addr",  64'(mem_addr), 64'h100);
        check("t1_mem_instr", 64'(mem_instr), 64'd1);
        check("t1_mem_wstrb", 64'(mem_wstrb), 64'd0);
        up_valid  = 2'b00;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        step();
        check("t1_mem_valid_clr", 64'(mem_valid), 64'd0);
        check("t1_up_ready",      64'(up_ready), 64'b01);
        check("t1_up_rdata",      64'(up_rdata), 64'hCAFE_0001);
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        check("t1_up_ready_end",  64'(up_ready), 64'd0);
        check("t1_rdata_hold",    64'(up_rdata), 64'hCAFE_0001);

        // Both ports request continuously: port 0 just won, so 1,0,1,0
        up_instr = 2'b00;
        up_addr  = {32'h0000_2000, 32'h0000_1000};
        up_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_mem_valid();
            check("t2_mem_addr", 64'(mem_addr), (k % 2 == 0) ? 64'h2000 : 64'h1000);
            mem_ready = 1'b1;
            mem_rdata = 32'h5000 + 32'(k);
            step();
            check("t2_grant", 64'(up_ready), (k % 2 == 0) ? 64'b10 : 64'b01);
            check("t2_rdata", 64'(up_rdata), 64'h5000 + 64'(k));
            mem_ready = 1'b0;
            step();
        end

        // Port 1 write with a 5-cycle slave wait; master drops valid after grant
        up_valid        = 2'b10;
        up_addr[63:32]  = 32'h0000_0020;
        up_wdata[63:32] = 32'hDEAD_BEEF;
        up_wstrb[7:4]   = 4'b0011;
        wait_mem_valid();
        check("t3_mem_addr",  64'(mem_addr), 64'h20);
        check("t3_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("t3_mem_wstrb", 64'(mem_wstrb), 64'h3);
        up_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_hold_valid", 64'(mem_valid), 64'd1);
            check("t3_hold_addr",  64'(mem_addr), 64'h20);
            check("t3_hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
            check("t3_hold_wstrb", 64'(mem_wstrb), 64'h3);
            check("t3_no_ready",   64'(up_ready), 64'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        check("t3_up_ready", 64'(up_ready), 64'b10);
        check("t3_up_rdata", 64'(up_rdata), 64'h0BAD_F00D);
        mem_ready = 1'b0;
        step();
        check("t3_up_ready_end", 64'(up_ready), 64'd0);
        step();
        check("t3_no_second",    64'(up_ready), 64'd0);
        check("t3_idle_valid",   64'(mem_valid), 64'd0);

        // Reset during BUSY
        up_valid       = 2'b10;
        up_addr[63:32] = 32'h0000_0040;
        up_wstrb       = '0;
        wait_mem_valid();
        #2;
        reset = 1'b1;
        #1;
        check("t4_async_valid", 64'(mem_valid), 64'd0);
        check("t4_async_ready", 64'(up_ready), 64'd0);
        check("t4_async_rdata", 64'(up_rdata), 64'd0);
        step();
        reset    = 1'b0;
        up_valid = 2'b11;
        up_addr  = {32'h0000_0040, 32'h0000_1000};
        step();
        check("t4_regrant_valid", 64'(mem_valid), 64'd1);
        check("t4_regrant_addr",  64'(mem_addr), 64'h1000);
        up_valid  = 2'b00;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0077;
        step();
        check("t4_up_ready", 64'(up_ready), 64'b01);
        mem_ready = 1'b0;
        step();

`ifdef PICORV32_ARB_TIMEOUT_EN
        // Slave never answers: abort at the end of the 8th BUSY cycle
        up_valid      = 2'b01;
        up_addr[31:0] = 32'h0000_0300;
        wait_mem_valid();
        up_valid = 2'b00;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t5_no_err",   64'(err_timeout), 64'd0);
            check("t5_no_ready", 64'(up_ready), 64'd0);
        end
        step();
        check("t5_err",        64'(err_timeout), 64'd1);
        check("t5_up_ready",   64'(up_ready), 64'b01);
        check("t5_up_rdata",   64'(up_rdata), 64'hFFFF_FFFF);
        check("t5_valid_clr",  64'(mem_valid), 64'd0);
        step();
        check("t5_err_end",    64'(err_timeout), 64'd0);
        check("t5_ready_end",  64'(up_ready), 64'd0);

        // mem_ready on the 8th BUSY cycle beats the timeout
        up_valid = 2'b01;
        wait_mem_valid();
        up_valid = 2'b00;
        for (int i = 0; i < 7; i++) step();
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5_0008;
        step();
        check("t6_no_err",   64'(err_timeout), 64'd0);
        check("t6_up_ready", 64'(up_ready), 64'b01);
        check("t6_up_rdata", 64'(up_rdata), 64'hA5A5_0008);
        mem_ready = 1'b0;
        step();
        check("t6_no_err_after", 64'(err_timeout), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
